// File: rtl/freq_gate_counter_pkg.sv
// Shared definitions for the frequency counter datapath and its display converter.
package freq_pkg;

   localparam int WIDTH_DEFAULT  = 12;
   localparam int CLK_HZ_DEFAULT = 100_000_000;

   typedef logic [WIDTH_DEFAULT-1:0] count_t;

   function automatic logic [31:0] max_count(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/freq_gate_counter_sync_edge_detect.sv
// Two-flop synchronizer plus delay flop; emits one registered pulse per rising transition.
module sync_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic edge_pulse
);

   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;
   logic dly_q, dly_d;
   logic pulse_q, pulse_d;

   // Pulse is registered so a rise first sampled at edge n lands in the counter at edge n+3.
   always_comb begin
      sync1_d = async_in;
      sync2_d = sync1_q;
      dly_d   = sync2_q;
      pulse_d = sync2_q & ~dly_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dly_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         dly_q   <= dly_d;
         pulse_q <= pulse_d;
      end
   end

   assign edge_pulse = pulse_q;

endmodule

// File: rtl/freq_gate_counter.sv
// Counts rising edges of sig_in over a fixed gate window and latches the saturated result.
module freq_gate_counter
   import freq_pkg::*;
#(
   parameter int CLK_HZ      = CLK_HZ_DEFAULT,
   parameter int GATE_CYCLES = 100_000_000,
   parameter int WIDTH       = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   output logic [WIDTH-1:0] count_out,
   output logic             valid,
   output logic             overflow
);

   localparam int GW = $clog2(GATE_CYCLES);
   localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
   localparam logic [WIDTH-1:0] CNT_MAX   = WIDTH'(max_count(WIDTH));

   if (GATE_CYCLES < 4 || CLK_HZ < 1) begin : g_bad_params
      $error("freq_gate_counter: GATE_CYCLES must be >= 4 and CLK_HZ positive");
   end

   logic             edge_pulse;
   logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
   logic [WIDTH-1:0] edge_cnt_q, edge_cnt_d;
   logic             sat_q, sat_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;
   logic             close;
   logic             at_max;

   sync_edge_detect u_sync (
      .clk        (clk),
      .rst        (rst),
      .async_in   (sig_in),
      .edge_pulse (edge_pulse)
   );

   always_comb begin
      close      = (gate_cnt_q == GATE_LAST);
      at_max     = (edge_cnt_q == CNT_MAX);
      gate_cnt_d = close ? '0 : gate_cnt_q + 1'b1;
      edge_cnt_d = edge_cnt_q;
      sat_d      = sat_q;
      count_d    = count_q;
      ovf_d      = ovf_q;
      valid_d    = 1'b0;

      if (edge_pulse) begin
         if (at_max) sat_d = 1'b1;
         else        edge_cnt_d = edge_cnt_q + 1'b1;
      end

      // A pulse coincident with close has already been folded into edge_cnt_d/sat_d.
      if (close) begin
         count_d    = edge_cnt_d;
         ovf_d      = sat_d;
         valid_d    = 1'b1;
         edge_cnt_d = '0;
         sat_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         sat_q      <= 1'b0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         sat_q      <= sat_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         valid_q    <= valid_d;
      end
   end

   assign count_out = count_q;
   assign overflow  = ovf_q;
   assign valid     = valid_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Scoreboard bench for freq_gate_counter: a 12-bit and a 4-bit instance share stimulus.
module tb_freq_gate_counter;

   localparam int GATE = 100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sig_in = 1'b0;
   logic [11:0] count12;
   logic        valid12, ovf12;
   logic [3:0]  count4;
   logic        valid4, ovf4;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   typedef struct {
      logic [11:0] c12;
      logic        o12;
      logic [3:0]  c4;
      logic        o4;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   freq_gate_counter #(.GATE_CYCLES(GATE), .WIDTH(12)) dut12 (
      .clk(clk), .rst(rst), .sig_in(sig_in),
      .count_out(count12), .valid(valid12), .overflow(ovf12)
   );

   freq_gate_counter #(.GATE_CYCLES(GATE), .WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .sig_in(sig_in),
      .count_out(count4), .valid(valid4), .overflow(ovf4)
   );

   // cyc equals the number of clock edges since reset release
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      logic exp_v;
      exp_t e;
      if (!rst) begin
         exp_v = (cyc != 0) && (cyc % GATE == 0);
         checks++;
         if (valid12 !== exp_v) begin
            failures++;
            $display("FAIL valid12 cyc=%0d got=%b exp=%b", cyc, valid12, exp_v);
         end
         checks++;
         if (valid4 !== exp_v) begin
            failures++;
            $display("FAIL valid4 cyc=%0d got=%b exp=%b", cyc, valid4, exp_v);
         end
         if (valid12 === 1'b1 || valid4 === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_result cyc=%0d got=valid exp=no_result_pending", cyc);
            end else begin
               e = q.pop_front();
               checks++;
               if (count12 !== e.c12) begin
                  failures++;
                  $display("FAIL count12 cyc=%0d got=%0d exp=%0d", cyc, count12, e.c12);
               end
               checks++;
               if (ovf12 !== e.o12) begin
                  failures++;
                  $display("FAIL ovf12 cyc=%0d got=%b exp=%b", cyc, ovf12, e.o12);
               end
               checks++;
               if (count4 !== e.c4) begin
                  failures++;
                  $display("FAIL count4 cyc=%0d got=%0d exp=%0d", cyc, count4, e.c4);
               end
               checks++;
               if (ovf4 !== e.o4) begin
                  failures++;
                  $display("FAIL ovf4 cyc=%0d got=%b exp=%b", cyc, ovf4, e.o4);
               end
            end
         end
      end
   end

   function automatic logic pat(input int e, input int period, input int high);
      return ((e - 1) % period) < high;
   endfunction

   task automatic push(input int c12, input logic o12, input int c4, input logic o4);
      exp_t e;
      e.c12 = 12'(c12);
      e.o12 = o12;
      e.c4  = 4'(c4);
      e.o4  = o4;
      q.push_back(e);
   endtask

   // Value for edge e is driven on the falling edge before it.
   task automatic drive_pattern(input int first_e, input int last_e, input int period, input int high);
      for (int e = first_e; e <= last_e; e++) begin
         sig_in = pat(e, period, high);
         @(negedge clk);
      end
   endtask

   task automatic drive_const(input int n, input logic v);
      for (int i = 0; i < n; i++) begin
         sig_in = v;
         @(negedge clk);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if (count12 !== 12'd0 || ovf12 !== 1'b0 || valid12 !== 1'b0) begin
         failures++;
         $display("FAIL %s_dut12 got count=%0d ovf=%b valid=%b exp=0/0/0", name, count12, ovf12, valid12);
      end
      checks++;
      if (count4 !== 4'd0 || ovf4 !== 1'b0 || valid4 !== 1'b0) begin
         failures++;
         $display("FAIL %s_dut4 got count=%0d ovf=%b valid=%b exp=0/0/0", name, count4, ovf4, valid4);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      sig_in = 1'b0;
      repeat (5) @(negedge clk);
      check_outputs_zero("in_reset");
      q.delete();
      rst = 1'b0;
   endtask

   task automatic flush(input string name);
      repeat (2) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL %s_pending got=%0d results_outstanding exp=0", name, q.size());
      end
   endtask

   task automatic test_reset();
      #1;
      check_outputs_zero("reset_at_start");
      do_reset();
   endtask

   task automatic test_idle();
      do_reset();
      repeat (3) push(0, 1'b0, 0, 1'b0);
      drive_const(3 * GATE, 1'b0);
      flush("idle");
   endtask

   task automatic test_periodic();
      do_reset();
      repeat (2) push(10, 1'b0, 10, 1'b0);
      drive_pattern(1, 2 * GATE, 10, 5);
      flush("periodic");
   endtask

   task automatic test_saturation();
      do_reset();
      push(25, 1'b0, 15, 1'b1);
      push(0, 1'b0, 0, 1'b0);
      drive_pattern(1, GATE, 4, 2);
      drive_const(GATE, 1'b0);
      flush("saturation");
   endtask

   task automatic test_boundary();
      // Rise sampled at edge 97 (close at 100) lands in the closing window.
      do_reset();
      push(1, 1'b0, 1, 1'b0);
      push(0, 1'b0, 0, 1'b0);
      drive_const(96, 1'b0);
      drive_const(2 * GATE - 96, 1'b1);
      flush("boundary_early");
      // One edge later it spills into the next window.
      do_reset();
      push(0, 1'b0, 0, 1'b0);
      push(1, 1'b0, 1, 1'b0);
      drive_const(97, 1'b0);
      drive_const(2 * GATE - 97, 1'b1);
      flush("boundary_late");
   endtask

   task automatic test_reset_mid();
      do_reset();
      push(25, 1'b0, 15, 1'b1);
      drive_pattern(1, GATE, 4, 2);
      drive_pattern(GATE + 1, GATE + 50, 10, 5);
      #2;
      rst = 1'b1;
      #1;
      check_outputs_zero("async_reset");
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL reset_mid_pending got=%0d exp=0", q.size());
      end
      do_reset();
      push(10, 1'b0, 10, 1'b0);
      drive_pattern(1, GATE, 10, 5);
      flush("reset_mid");
   endtask

   task automatic test_constant_high();
      do_reset();
      push(1, 1'b0, 1, 1'b0);
      push(0, 1'b0, 0, 1'b0);
      push(0, 1'b0, 0, 1'b0);
      drive_const(3 * GATE, 1'b1);
      flush("constant_high");
   endtask

   initial begin
      test_reset();
      test_idle();
      test_periodic();
      test_saturation();
      test_boundary();
      test_reset_mid();
      test_constant_high();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/freq_gate_counter.md
# freq_gate_counter

Input stage of the frequency counter. It counts rising edges of an asynchronous input signal over a fixed gate window of `GATE_CYCLES` clocks, then latches the saturated count. The latched count drives the binary input of `bin_to_bcd`, which converts it for the display path. A one-cycle `valid` strobe marks each new result.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000: system clock frequency; documentation only.
- `GATE_CYCLES`, 100_000_000: gate window length in clocks (1 s at 100 MHz). Must be ≥ 4.
- `WIDTH`, 12: result width; matches the `bin_to_bcd` input.

Ports:
- `clk`: input, 1 bit. Single system clock; all logic on the rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `sig_in`: input, 1 bit. Measured signal, asynchronous to `clk`.
- `count_out`: output, `WIDTH` bits. Edge count of the last completed window, saturated at 2^WIDTH−1.
- `valid`: output, 1 bit. One-cycle pulse in the cycle `count_out`/`overflow` update.
- `overflow`: output, 1 bit. Set if the last completed window saturated.

## Operation
- **Synchronizer:** `sig_in` → 2-FF synchronizer → one delay FF. `edge_pulse` = synced & ~delayed, so exactly one pulse per rising transition.
- **Detection limit:** `sig_in` high and low phases must each be ≥ 2 clk periods to be counted reliably. Shorter pulses may be lost. A constant level produces no counts.
- **Gate counter `gate_cnt`:**
  - Width is $clog2(GATE_CYCLES); runs 0 … GATE_CYCLES−1, then wraps to 0.
  - The window closes on the edge where `gate_cnt` == GATE_CYCLES−1.
- **Edge counter `edge_cnt`:**
  - `WIDTH` bits, plus a sticky `sat` flag.
  - On `edge_pulse`, increments. If already 2^WIDTH−1, it holds and `sat` is set. No wrap-around.
- **Window close edge, in one cycle:**
  - `count_out` ← `edge_cnt` + `edge_pulse`, saturated.
  - `overflow` ← `sat` OR (`edge_cnt` == max AND `edge_pulse`).
  - `valid` ← 1.
  - `edge_cnt` ← 0, `sat` ← 0.
- **Simultaneous events:** an `edge_pulse` coincident with window close is counted in the closing window, never the next one and never dropped.
- **Hold between windows:** `count_out` and `overflow` hold their value until the next close. `valid` is 0 on every other cycle.
- **Sequencer states:** RUN only; no idle/armed mode. Counting starts on the first edge after `rst` deasserts.
- **Reset values:** `count_out`=0, `valid`=0, `overflow`=0, `gate_cnt`=0, `edge_cnt`=0, `sat`=0, synchronizer FFs=0.
- **Reset mid-window:** discards the partial count. Outputs go to 0 asynchronously.

## Timing
- **Edge latency:** a `sig_in` rise first sampled at clk edge n reaches `edge_cnt` at edge n+3. `edge_pulse` is high in the cycle after edge n+2.
- **Valid cadence:**
  - First `valid` is asserted after edge GATE_CYCLES following `rst` release; the first window spans exactly GATE_CYCLES edges.
  - Subsequent pulses follow every GATE_CYCLES clocks exactly.
- **Output update:** `count_out`, `overflow` and `valid` are registered and change on the same edge.
- **Pipeline skew:** the 3-cycle synchronizer latency shifts the effective window by a constant; window length is unaffected.
- **Downstream use:** `bin_to_bcd` is combinational. Its digits are stable one clk after `valid`.

## Structure
- **Shared package `freq_pkg`:**
  - `WIDTH_DEFAULT` = 12.
  - `CLK_HZ_DEFAULT`.
  - Function `max_count(width)` = 2^width−1.
  - Typedef `count_t` = logic [WIDTH_DEFAULT−1:0].
- **Sub-module `sync_edge_detect`:**
  - Ports: `clk`, `rst`, async in, `edge_pulse` out.
  - Contains the 2-FF synchronizer plus delay FF.
  - Reused for front-panel button inputs.
- **Top level:** gate counter, saturating edge counter and output registers.

## Test plan
All scenarios use `GATE_CYCLES`=100 unless noted.
- **Idle input:** reset 5 cycles, `sig_in`=0 → `valid` pulses at edge 100 after release and every 100 cycles after; `count_out`=0, `overflow`=0.
- **Periodic input:** `sig_in` period 10 clks (5 high/5 low), phase-locked to the window → `count_out`=10 every window, `overflow`=0.
- **Saturation:** `WIDTH`=4, `sig_in` period 4 clks (2/2), 25 rising transitions per window → `count_out`=15, `overflow`=1. Next window with `sig_in`=0 → `count_out`=0, `overflow`=0.
- **Boundary edge:**
  - `sig_in` rise sampled 3 edges before window close → counted in the closing window (`count_out`=1).
  - The same rise one cycle later → closing window 0, next window 1.
- **Reset mid-window:** 5 edges, then `rst` asserted between clk edges at cycle 50 → outputs 0 immediately. After release, next `valid` at 100 cycles, counting only post-reset edges.
- **Constant high:** `sig_in` held at 1 for 3 windows → one count in the first window (the initial rise), then 0 in the following windows.
